window_cache_filler: RTL

//  Write-side partner of the window cache. Accepts a raster stream of integral-image words
//  (row-major, WINDOW_SIZE x WINDOW_SIZE) from the integral image cache. Packs them into

---
 rtl/window_cache_filler.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/window_cache_filler.sv
// window_cache_filler: packs a row-major WINDOW_SIZE x WINDOW_SIZE stream of
// integral-image words into WORDS-wide blocks and writes each block to the
// window cache RAM at row*BLOCKS + col/WORDS.
// Optional feature macro: WINDOW_CACHE_FILLER_CHECKSUM_EN (running word sum).
module window_cache_filler #(
  parameter int WORD_SIZE   = 32,
  parameter int WORDS       = 4,
  parameter int WINDOW_SIZE = 20,
  parameter int BLOCKS      = 5,
  parameter int ADDR_WIDTH  = 7,
  parameter int INDEX_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORD_SIZE-1:0]         in_data,
  output logic                         wr_en,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic [WORDS*WORD_SIZE-1:0]   wr_data,
  output logic [31:0]                  checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX  = INDEX_WIDTH'(WINDOW_SIZE - 1);
  localparam logic [INDEX_WIDTH-1:0] LAST_LANE = INDEX_WIDTH'(WORDS - 1);

  state_t                       state_q, state_d;
  logic [INDEX_WIDTH-1:0]       row_q, row_d;
  logic [INDEX_WIDTH-1:0]       col_q, col_d;
  logic [INDEX_WIDTH-1:0]       lane_q, lane_d;
  logic [INDEX_WIDTH-1:0]       blk_q, blk_d;
  logic [WORDS*WORD_SIZE-1:0]   buf_q, buf_d;
  logic [WORDS*WORD_SIZE-1:0]   merged;
  logic                         wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]        wr_addr_q, wr_addr_d;
  logic [WORDS*WORD_SIZE-1:0]   wr_data_q, wr_data_d;
  logic                         accept;
  logic                         last_col;
  logic                         block_end;

  assign accept    = in_valid && (state_q == FILL);
  assign last_col  = (col_q == LAST_IDX);
  assign block_end = (lane_q == LAST_LANE) || last_col;

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign in_ready = (state_q == FILL);
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

  // Lane buffer with the incoming word dropped into its lane; unfilled lanes stay 0.
  always_comb begin
    merged = buf_q;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (lane_q == INDEX_WIDTH'(i)) begin
        merged[i*WORD_SIZE +: WORD_SIZE] = in_data;
      end
    end
  end

  // Next-state: FSM, raster counters, block packing and write strobe.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    lane_d    = lane_q;
    blk_d     = blk_q;
    buf_d     = buf_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          row_d   = '0;
          col_d   = '0;
          lane_d  = '0;
          blk_d   = '0;
          buf_d   = '0;
        end
      end
      FILL: begin
        if (accept) begin
          if (block_end) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_WIDTH'(int'(row_q) * BLOCKS + int'(blk_q));
            wr_data_d = merged;
            buf_d     = '0;
          end else begin
            buf_d = merged;
          end
          if (last_col) begin
            col_d  = '0;
            row_d  = row_q + 1'b1;
            lane_d = '0;
            blk_d  = '0;
            if (row_q == LAST_IDX) begin
              state_d = DONE;
            end
          end else begin
            col_d = col_q + 1'b1;
            if (lane_q == LAST_LANE) begin
              lane_d = '0;
              blk_d  = blk_q + 1'b1;
            end else begin
              lane_d = lane_q + 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      lane_q    <= '0;
      blk_q     <= '0;
      buf_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      lane_q    <= lane_d;
      blk_q     <= blk_d;
      buf_q     <= buf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef WINDOW_CACHE_FILLER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;

  // Running sum of accepted words, cleared when a fill is accepted.
  always_comb begin
    sum_d = sum_q;
    if ((state_q == IDLE) && start) begin
      sum_d = '0;
    end else if (accept) begin
      sum_d = sum_q + 32'(in_data);
    end
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule
